hs32_xmem: RTL
==============

# hs32_xmem

External memory bus controller between the internal memory arbiter's external port and a 16-bit asynchronous SRAM-style bus. Each 32-bit request from the arbiter becomes two sequenced half-word accesses:

- low half at the word address;
- high half at word address + 2.

The phases have programmable wait states. A one-cycle `done` pulse completes the arbiter's valid/done handshake.

## Interface
- `WAIT_CYCLES`, default 1: extra strobe cycles per half-word phase; legal range 0..15.
- `clk` in 1: single clock; all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `addr` in 32: request byte address; bits [1:0] ignored (word-aligned).
- `rw` in 1: 1 = write, 0 = read.
- `dtw` in 32: write data.
- `valid` in 1: request present.
- `dtr` out 32: read data; registered; valid when `done`=1 and held until next read completes.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `xaddr` out 32: external half-word address; bit 0 always 0.
- `xdout` out 16: external write data.
- `xdout_en` out 1: drive enable for external data pins.
- `xdin` in 16: external read data.
- `xcs_n` out 1: chip select, active low.
- `xoe_n` out 1: output enable, active low, reads only.
- `xwe_n` out 1: write strobe, active low, writes only.

## Operation
FSM states: IDLE, LO, GAP, HI, DONE.

- **IDLE:** if `valid`=1, latch `addr[31:2]`, `rw`, and `dtw` into internal registers and go to LO. Later changes on the inputs are ignored until the next IDLE.
- **LO:**
  - `xaddr={a[31:2],2'b00}`, `xcs_n`=0.
  - Read: `xoe_n`=0. Write: `xwe_n`=0, `xdout`=`dtw[15:0]`.
  - Lasts `WAIT_CYCLES`+1 cycles, timed by the wait counter.
  - Read samples `xdin` into `dtr[15:0]` on the last cycle.
- **GAP:** one cycle with `xcs_n`=`xoe_n`=`xwe_n`=1. `xaddr` and `xdout` hold their values.
- **HI:**
  - `xaddr={a[31:2],2'b10}`.
  - Write: `xdout`=`dtw[31:16]`. Read: samples `xdin` into `dtr[31:16]` on the last cycle.
  - Same length and strobe rules as LO.
- **DONE:** `done`=1 for exactly one cycle, all strobes inactive, then go to IDLE.
- `xdout_en`=1 from LO through HI on writes only; 0 otherwise.
- The half-word order is fixed (LO before HI) for both reads and writes; little-endian.
- A write leaves `dtr` unchanged.

## Timing
- Reset values:
  - state = IDLE.
  - `done`=0, `busy`=0.
  - `xcs_n`=`xoe_n`=`xwe_n`=1, `xdout_en`=0.
  - `xaddr`=0, `xdout`=0, `dtr`=0, wait counter = 0.
- All outputs are registered; there is no combinational input-to-output path.
- Latency: with `valid` first seen in IDLE at cycle 0, `done`=1 in cycle 2·`WAIT_CYCLES`+4. That is 6 cycles at W=1 and 4 cycles at W=0.
- Back-to-back requests: if `valid` is high in the cycle after DONE, a new transaction starts. The minimum request-to-request period is 2·`WAIT_CYCLES`+5 cycles.
- `valid` dropping mid-transaction does not abort it; the transaction completes and `done` still pulses.
- Asserting `rstn` low mid-transaction forces all reset values immediately (asynchronously). No `done` is issued and partial `dtr` updates are discarded to 0.
- The wait counter reloads to `WAIT_CYCLES` on entry to LO and HI and counts down to 0. At `WAIT_CYCLES`=0, each phase is exactly one cycle.

## Structure
- Shared defines header `hs32_xmem_defs`: state encodings (IDLE=0, LO=1, GAP=2, HI=3, DONE=4, 3-bit) and the `WAIT_CYCLES` legal maximum.
- Sub-module `hs32_xmem_wcnt`: 4-bit loadable down-counter with `load`, `value`, and `zero` outputs. The top-level FSM advances on `zero`.
- The block connects directly to the arbiter's external port: `addr`, `rw`, `dout`→`dtw`, `din`←`dtr`, `valid`, `done`.

## Test plan
- **Reset:** hold `rstn`=0 with random inputs → all outputs at reset values; release → `busy`=0 and `done` never pulses without `valid`.
- **Read, W=1:** `addr`=0x00001006, `rw`=0; memory model returns 0xBEEF at 0x1004 and 0xCAFE at 0x1006 → `xaddr` sequence 0x1004 then 0x1006, `xoe_n` low 2 cycles each, `done` in cycle 6, `dtr`=0xCAFEBEEF.
- **Write, W=0:** `addr`=0x20, `dtw`=0x12345678 → `xwe_n` low 1 cycle with `xdout`=0x5678 @0x20, GAP, then `xdout`=0x1234 @0x22; `done` in cycle 4; `dtr` unchanged.
- **Back-to-back:** hold `valid` high across two reads → second LO begins 2 cycles after the first `done` cycle; exactly two `done` pulses.
- **Input change mid-transaction:** deassert `valid` and change `addr`/`dtw` during LO → the original transaction completes unchanged and `done` pulses once.
- **Reset mid-transaction:** pull `rstn` low during HI of a write → strobes go inactive immediately, `xdout_en`=0, no `done`; the next request after release runs normally.

Source files
------------

// File: rtl/hs32_xmem_pkg.sv
// Shared types and constants for the hs32 external memory bus controller.
package hs32_xmem_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned HALF_W   = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_GAP  = 3'd2,
    ST_HI   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Request captured from the arbiter when a transaction is accepted.
  typedef struct packed {
    logic [WORD_W-3:0] word;
    logic              is_wr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/hs32_xmem_wcnt.sv
// Loadable 4-bit down-counter that times the strobe length of each half-word phase.
module hs32_xmem_wcnt
  import hs32_xmem_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_value,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Reload wins; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_value  = r_cnt;
  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/hs32_xmem.sv
// Splits each 32-bit arbiter request into low/high half-word accesses on a 16-bit async SRAM bus.
module hs32_xmem
  import hs32_xmem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] addr,
  input  logic              rw,
  input  logic [WORD_W-1:0] dtw,
  input  logic              valid,
  output logic [WORD_W-1:0] dtr,
  output logic              done,
  output logic              busy,
  output logic [WORD_W-1:0] xaddr,
  output logic [HALF_W-1:0] xdout,
  output logic              xdout_en,
  input  logic [HALF_W-1:0] xdin,
  output logic              xcs_n,
  output logic              xoe_n,
  output logic              xwe_n
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e           r_state;
  req_t             r_req;
  logic             w_cnt_load;
  logic             w_cnt_zero;
  logic [CNT_W-1:0] w_cnt_value;

  // Counter reloads on the transitions into LO and HI.
  assign w_cnt_load = ((r_state == ST_IDLE) && valid) || (r_state == ST_GAP);

  hs32_xmem_wcnt u_wcnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_cnt_load),
    .i_load_val (WAIT_LD),
    .o_value    (w_cnt_value),
    .o_zero_c   (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      dtr      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      xaddr    <= '0;
      xdout    <= '0;
      xdout_en <= 1'b0;
      xcs_n    <= 1'b1;
      xoe_n    <= 1'b1;
      xwe_n    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid) begin
            r_req    <= '{word: addr[WORD_W-1:2], is_wr: rw, wdata: dtw};
            r_state  <= ST_LO;
            busy     <= 1'b1;
            xaddr    <= {addr[WORD_W-1:2], 2'b00};
            xcs_n    <= 1'b0;
            xoe_n    <= rw;
            xwe_n    <= ~rw;
            xdout_en <= rw;
            if (rw) xdout <= dtw[HALF_W-1:0];
          end
        end
        ST_LO: begin
          if (w_cnt_zero) begin
            if (!r_req.is_wr) dtr[HALF_W-1:0] <= xdin;
            r_state <= ST_GAP;
            xcs_n   <= 1'b1;
            xoe_n   <= 1'b1;
            xwe_n   <= 1'b1;
          end
        end
        ST_GAP: begin
          r_state <= ST_HI;
          xaddr   <= {r_req.word, 2'b10};
          xcs_n   <= 1'b0;
          xoe_n   <= r_req.is_wr;
          xwe_n   <= ~r_req.is_wr;
          if (r_req.is_wr) xdout <= r_req.wdata[WORD_W-1:HALF_W];
        end
        ST_HI: begin
          if (w_cnt_zero) begin
            if (!r_req.is_wr) dtr[WORD_W-1:HALF_W] <= xdin;
            r_state  <= ST_DONE;
            done     <= 1'b1;
            xdout_en <= 1'b0;
            xcs_n    <= 1'b1;
            xoe_n    <= 1'b1;
            xwe_n    <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          xdout_en <= 1'b0;
          xcs_n    <= 1'b1;
          xoe_n    <= 1'b1;
          xwe_n    <= 1'b1;
        end
      endcase
    end
  end

  // Parameter legality, counter bound, and visibility of unaligned byte addresses.
  a_wait_legal: assert property (@(posedge clk) WAIT_CYCLES <= WAIT_MAX);
  a_cnt_range:  assert property (@(posedge clk) disable iff (!rstn) w_cnt_value <= WAIT_LD);
  c_unaligned:  cover property (@(posedge clk) disable iff (!rstn) valid && (addr[1:0] != 2'b00));

endmodule
